// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and arbitration mode constants for the priority arbiter
package arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/param_priority_arbiter_prio_find.sv
// prio_find: combinational highest-set-bit finder returning one-hot, index and found flag
module prio_find #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] v,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) idx = W'(i);
        found  = |v;
        onehot = found ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/param_priority_arbiter.sv
// param_priority_arbiter: registered N-way arbiter, fixed priority or round-robin, grant held until release
module param_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         valid
);
    state_t       state;
    logic [W-1:0] ptr;
    logic [N-1:0] masked, rev, vec, f_hot, nxt_gnt;
    logic [W-1:0] f_idx, win;
    logic         found, rel;

    always_comb begin
        // The outgoing grantee sits out the arbitration that immediately follows its release
        masked = (state == GRANT) ? (req & ~gnt) : req;
        rev = '0;
        for (int j = 0; j < N; j++)
            rev[N-1-j] = masked[W'((int'(ptr) + j) % N)];
        vec     = (mode == MODE_RR) ? rev : masked;
        win     = (mode == MODE_RR) ? W'((int'(ptr) + N - 1 - int'(f_idx)) % N) : f_idx;
        nxt_gnt = (mode == MODE_RR) ? (N'(1) << win) : f_hot;
        rel     = ack | ~req[gnt_idx] | ~enable;
    end

    prio_find #(.N(N)) u_find (
        .v      (vec),
        .onehot (f_hot),
        .idx    (f_idx),
        .found  (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            valid   <= 1'b0;
        end else if (state == IDLE || rel) begin
            if (enable && found) begin
                state   <= GRANT;
                gnt     <= nxt_gnt;
                gnt_idx <= win;
                valid   <= 1'b1;
                if (mode == MODE_RR) ptr <= (win == W'(N-1)) ? '0 : win + 1'b1;
            end else begin
                state   <= IDLE;
                gnt     <= '0;
                gnt_idx <= '0;
                valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_param_priority_arbiter.sv
// tb_param_priority_arbiter: directed self-checking bench for the N=8 priority arbiter
module tb_param_priority_arbiter;
    logic       clk = 1'b0;
    logic       rst_n, enable, mode, ack;
    logic [7:0] req, gnt;
    logic [2:0] gnt_idx;
    logic       valid;
    int         n_tests = 0;
    int         n_fail = 0;

    param_priority_arbiter #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .mode    (mode),
        .req     (req),
        .ack     (ack),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".idx"}, 32'(gnt_idx), 32'(i));
        check({tag, ".valid"}, 32'(valid), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; req = '0; ack = 1'b0;
        #2;
        check_out("reset", 8'h00, 3'd0, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step();
        check_out("post_reset", 8'h00, 3'd0, 1'b0);

        // fixed priority: highest index wins, grant holds while req changes
        enable = 1'b1; req = 8'b0110_0100;
        step();
        check_out("fixed_first", 8'h40, 3'd6, 1'b1);
        req = 8'b1110_0100;
        step();
        check_out("fixed_hold", 8'h40, 3'd6, 1'b1);

        // ack gives back-to-back grant with the released index excluded
        req = 8'b0110_0100; ack = 1'b1;
        step();
        check_out("b2b_excl", 8'h20, 3'd5, 1'b1);
        ack = 1'b0;
        step();
        check_out("b2b_hold", 8'h20, 3'd5, 1'b1);
        req = '0; ack = 1'b1;
        step();
        check_out("release_idle", 8'h00, 3'd0, 1'b0);
        ack = 1'b0;

        for (int k = 0; k < 4; k++) begin
            step();
            check("idle_noreq", 32'(valid), 32'd0);
        end
        ack = 1'b1;
        step();
        check_out("idle_ack", 8'h00, 3'd0, 1'b0);
        ack = 1'b0;

        // round-robin from ptr=0 with every requester active, including wrap
        mode = 1'b1; req = 8'hFF;
        step();
        check_out("rr_0", 8'h01, 3'd0, 1'b1);
        ack = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("rr_%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1);
        end
        ack = 1'b0;

        // mode change mid-grant only affects the next arbitration
        mode = 1'b0;
        step();
        check_out("mode_hold", 8'h01, 3'd0, 1'b1);
        ack = 1'b1;
        step();
        check_out("mode_fixed", 8'h80, 3'd7, 1'b1);
        ack = 1'b0;

        // withdrawal releases without ack and re-arbitrates
        req = 8'b0000_1000;
        step();
        check_out("wd_grant3", 8'h08, 3'd3, 1'b1);
        req = 8'b0000_0010;
        step();
        check_out("wd_rearb", 8'h02, 3'd1, 1'b1);
        req = '0;
        step();
        check_out("wd_idle", 8'h00, 3'd0, 1'b0);

        // disable mid-grant; RR pointer (1) survives across the disabled period
        mode = 1'b1; req = 8'hFF;
        step();
        check_out("rr_ptr1", 8'h02, 3'd1, 1'b1);
        enable = 1'b0;
        step();
        check_out("disabled", 8'h00, 3'd0, 1'b0);
        step();
        check_out("disabled2", 8'h00, 3'd0, 1'b0);
        enable = 1'b1;
        step();
        check_out("reenable", 8'h04, 3'd2, 1'b1);

        // asynchronous reset mid-cycle clears outputs and the pointer
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 8'h00, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        step();
        check_out("rr_after_rst", 8'h01, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
